// File: rtl/icache_data_ways_if.sv
// icache_data_ways_if
//   Fetch-read and line-refill handshake bundle of the I-cache data array.
//   Signal suffixes are from the data array's point of view (_i = into the
//   array, _o = out of the array).
//   master : fetch unit / refill engine side
//   slave  : icache_data_ways side
//   Read    : rd_valid_i/rd_ready_o request, rd_index_i, rd_blk_addr_i,
//             rd_hit_way_i (late, response cycle), rd_data_o/rd_data_valid_o
//   Refill  : refill_start_i, refill_way_i, refill_index_i,
//             refill_valid_i/refill_ready_o beats, refill_data_i, refill_done_o
interface icache_data_ways_if #(
    parameter int IDX_LEN = 7,
    parameter int BLK_LEN = 6,
    parameter int WAYS    = 2,
    parameter int FETCH_W = 32
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                 rd_valid_i;
    logic                 rd_ready_o;
    logic [IDX_LEN-1:0]   rd_index_i;
    logic [BLK_LEN-1:0]   rd_blk_addr_i;
    logic [WAYS-1:0]      rd_hit_way_i;
    logic [FETCH_W-1:0]   rd_data_o;
    logic                 rd_data_valid_o;

    logic                 refill_start_i;
    logic [WAY_W-1:0]     refill_way_i;
    logic [IDX_LEN-1:0]   refill_index_i;
    logic                 refill_valid_i;
    logic [127:0]         refill_data_i;
    logic                 refill_ready_o;
    logic                 refill_done_o;

    modport master (
        output rd_valid_i, rd_index_i, rd_blk_addr_i, rd_hit_way_i,
        output refill_start_i, refill_way_i, refill_index_i, refill_valid_i, refill_data_i,
        input  rd_ready_o, rd_data_o, rd_data_valid_o, refill_ready_o, refill_done_o
    );

    modport slave (
        input  rd_valid_i, rd_index_i, rd_blk_addr_i, rd_hit_way_i,
        input  refill_start_i, refill_way_i, refill_index_i, refill_valid_i, refill_data_i,
        output rd_ready_o, rd_data_o, rd_data_valid_o, refill_ready_o, refill_done_o
    );
endinterface

// File: rtl/icache_data_ways.sv
// icache_data_ways
//   N-way I-cache data array built from 128-bit SRAM banks (BANKS per way,
//   SRAM n = way*BANKS + bank). Reads enable only the addressed bank in every
//   way and return one FETCH_W word a cycle later, way-selected by the late
//   hit vector. Line refill writes beat k into bank k of the victim way.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     bus (slave)       read / refill handshakes (see icache_data_ways_if)
//     sram_addr_o       per-SRAM address
//     sram_cen_o        per-SRAM chip enable, active-low
//     sram_wen_o        per-SRAM write enable, active-low
//     sram_wmask_o      per-SRAM bit write mask, active-low
//     sram_wdata_o      per-SRAM write data
//     sram_rdata_i      per-SRAM read data, valid the cycle after a read
module icache_data_ways #(
    parameter  int          IDX_LEN = 7,
    parameter  int          BLK_LEN = 6,
    parameter  int          WAYS    = 2,
    parameter  int          FETCH_W = 32,
    localparam int unsigned BANKS   = 2 ** (BLK_LEN - 4),
    localparam int unsigned NSRAM   = WAYS * BANKS
) (
    input  logic                       clk,
    input  logic                       rst,
    icache_data_ways_if.slave          bus,
    output logic [NSRAM*IDX_LEN-1:0]   sram_addr_o,
    output logic [NSRAM-1:0]           sram_cen_o,
    output logic [NSRAM-1:0]           sram_wen_o,
    output logic [NSRAM*128-1:0]       sram_wmask_o,
    output logic [NSRAM*128-1:0]       sram_wdata_o,
    input  logic [NSRAM*128-1:0]       sram_rdata_i
);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BANK_W  = BLK_LEN - 4;
    localparam int OFF_LSB = $clog2(FETCH_W / 8);
    localparam int WORD_W  = 4 - OFF_LSB;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    state_e              state_q, state_d;
    logic [BANK_W-1:0]   beat_q, beat_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [IDX_LEN-1:0]  ridx_q, ridx_d;
    logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
    logic [WORD_W-1:0]   rd_word_q, rd_word_d;
    logic                rd_vld_q, rd_vld_d;
    logic                done_q, done_d;

    logic                rd_acc;
    logic                beat_acc;
    logic [BANK_W-1:0]   rd_bank;
    logic [127:0]        hit_line;
    logic [OFF_LSB-1:0]  unused_byte_bits;

    // Byte bits below the fetch word are irrelevant to the array.
    assign unused_byte_bits = bus.rd_blk_addr_i[OFF_LSB-1:0];

    // Refill start has priority over a read in the same cycle.
    assign bus.rd_ready_o     = (state_q == IDLE) && !bus.refill_start_i;
    assign bus.refill_ready_o = (state_q == REFILL);
    assign rd_acc             = bus.rd_valid_i && bus.rd_ready_o;
    assign beat_acc           = bus.refill_valid_i && bus.refill_ready_o;
    assign rd_bank            = bus.rd_blk_addr_i[BLK_LEN-1:4];

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        way_d     = way_q;
        ridx_d    = ridx_q;
        rd_bank_d = rd_bank_q;
        rd_word_d = rd_word_q;
        rd_vld_d  = rd_acc;
        done_d    = 1'b0;

        if (rd_acc) begin
            rd_bank_d = rd_bank;
            rd_word_d = bus.rd_blk_addr_i[3:OFF_LSB];
        end

        case (state_q)
            IDLE: begin
                if (bus.refill_start_i) begin
                    state_d = REFILL;
                    way_d   = bus.refill_way_i;
                    ridx_d  = bus.refill_index_i;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                if (beat_acc) begin
                    beat_d = beat_q + BANK_W'(1);
                    if (beat_q == BANK_W'(BANKS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads and refill beats are mutually exclusive by state, so the two
    // enables never target an SRAM in the same cycle.
    always_comb begin
        sram_addr_o  = '0;
        sram_cen_o   = '1;
        sram_wen_o   = '1;
        sram_wmask_o = '1;
        sram_wdata_o = '0;
        for (int unsigned n = 0; n < NSRAM; n++) begin
            if (rd_acc && ((n % BANKS) == 32'(rd_bank))) begin
                sram_cen_o[n]                     = 1'b0;
                sram_addr_o[n*IDX_LEN +: IDX_LEN] = bus.rd_index_i;
            end
            if (beat_acc && (n == 32'(way_q) * BANKS + 32'(beat_q))) begin
                sram_cen_o[n]                     = 1'b0;
                sram_wen_o[n]                     = 1'b0;
                sram_wmask_o[n*128 +: 128]        = '0;
                sram_addr_o[n*IDX_LEN +: IDX_LEN] = ridx_q;
                sram_wdata_o[n*128 +: 128]        = bus.refill_data_i;
            end
        end
    end

    // Late way select: OR of the registered bank across hitting ways.
    always_comb begin
        hit_line = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (bus.rd_hit_way_i[w]) begin
                hit_line = hit_line | sram_rdata_i[(w * BANKS + 32'(rd_bank_q)) * 128 +: 128];
            end
        end
    end

    assign bus.rd_data_o       = rd_vld_q ? hit_line[32'(rd_word_q) * FETCH_W +: FETCH_W] : '0;
    assign bus.rd_data_valid_o = rd_vld_q;
    assign bus.refill_done_o   = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            way_q     <= '0;
            ridx_q    <= '0;
            rd_bank_q <= '0;
            rd_word_q <= '0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            way_q     <= way_d;
            ridx_q    <= ridx_d;
            rd_bank_q <= rd_bank_d;
            rd_word_q <= rd_word_d;
            rd_vld_q  <= rd_vld_d;
            done_q    <= done_d;
        end
    end
endmodule
